// File: rtl/pe_tile_pkg.sv
// rtl/pe_tile_pkg.sv - shared constants, opcode and switch-box select encodings for pe_tile_param
package pe_tile_pkg;

   // configuration bus targets (config_addr[31:16])
   localparam logic [15:0] TGT_CLB     = 16'h0004;
   localparam logic [15:0] TGT_CB1     = 16'h0005;
   localparam logic [15:0] TGT_CB0     = 16'h0006;
   localparam logic [15:0] TGT_SB_BASE = 16'h0007;
   localparam logic [15:0] TGT_COMMIT  = 16'h00FF;

   // CLB config word: [1:0] opcode, [2] output register enable
   localparam int CLB_CFG_W = 3;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2,
      OP_ADD = 2'd3
   } clb_op_e;

   // switch-box select: neighbouring side (s+1)%4, (s+2)%4, (s+3)%4 or the PE result
   typedef enum logic [1:0] {
      SB_SEL_S1 = 2'd0,
      SB_SEL_S2 = 2'd1,
      SB_SEL_S3 = 2'd2,
      SB_SEL_PE = 2'd3
   } sb_sel_e;

   // number of 32-bit configuration words holding 2 select bits per (side, track)
   function automatic int sb_words(input int num_tracks);
      return (8 * num_tracks + 31) / 32;
   endfunction

endpackage

// File: rtl/pe_tile_clb_param.sv
// rtl/pe_tile_clb_param.sv - WIDTH-bit ALU with optional registered result for the PE tile
module pe_tile_clb_param
   import pe_tile_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CLB_CFG_W-1:0] i_cfg,
   input  logic [WIDTH-1:0]     i_op_a,
   input  logic [WIDTH-1:0]     i_op_b,
   output logic [WIDTH-1:0]     o_pe_out
);

   clb_op_e          w_op;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] r_pe;

   assign w_op = clb_op_e'(i_cfg[1:0]);

   // combinational ALU; ADD wraps modulo 2^WIDTH with the carry discarded
   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_AND:  w_alu = i_op_a & i_op_b;
         OP_OR:   w_alu = i_op_a | i_op_b;
         OP_XOR:  w_alu = i_op_a ^ i_op_b;
         OP_ADD:  w_alu = i_op_a + i_op_b;
         default: w_alu = '0;
      endcase
   end

   // result register runs every cycle so switching to registered mode is glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pe <= '0;
      end else begin
         r_pe <= w_alu;
      end
   end

   assign o_pe_out = i_cfg[2] ? r_pe : w_alu;

endmodule

// File: rtl/pe_tile_param.sv
// rtl/pe_tile_param.sv - parametrised PE tile with double-buffered config; optional readback via PE_TILE_READBACK_EN
module pe_tile_param
   import pe_tile_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int NUM_TRACKS = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [31:0]                      config_addr,
   input  logic [31:0]                      config_data,
   input  logic                             config_we,
   input  logic                             config_re,
   input  logic [15:0]                      tile_id,
   input  logic [4*NUM_TRACKS*WIDTH-1:0]    in_wire,
   output logic [4*NUM_TRACKS*WIDTH-1:0]    out_wire,
   output logic [31:0]                      config_rdata,
   output logic                             config_rvalid
);

   localparam int SB_BITS  = 8 * NUM_TRACKS;
   localparam int SB_WORDS = sb_words(NUM_TRACKS);
   localparam int CB_W     = $clog2(2 * NUM_TRACKS);

   // address decode
   logic [15:0] w_target;
   logic [15:0] w_sb_idx;
   logic        w_hit;
   logic        w_is_clb;
   logic        w_is_cb1;
   logic        w_is_cb0;
   logic        w_is_sb;
   logic        w_is_commit;
   logic        w_we_hit;

   assign w_target    = config_addr[31:16];
   assign w_hit       = (config_addr[15:0] == tile_id);
   assign w_sb_idx    = w_target - TGT_SB_BASE;
   assign w_is_clb    = (w_target == TGT_CLB);
   assign w_is_cb1    = (w_target == TGT_CB1);
   assign w_is_cb0    = (w_target == TGT_CB0);
   assign w_is_sb     = (w_target >= TGT_SB_BASE) && (w_target < (TGT_SB_BASE + 16'(SB_WORDS)));
   assign w_is_commit = (w_target == TGT_COMMIT);
   assign w_we_hit    = config_we && w_hit;

   // shadow and active banks
   logic [CLB_CFG_W-1:0] r_clb_sh, r_clb_act;
   logic [CB_W-1:0]      r_cb0_sh, r_cb0_act;
   logic [CB_W-1:0]      r_cb1_sh, r_cb1_act;
   logic [SB_BITS-1:0]   r_sb_sh,  r_sb_act;

   // shadow writes; each register keeps only as many data bits as it holds
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clb_sh <= '0;
         r_cb0_sh <= '0;
         r_cb1_sh <= '0;
         r_sb_sh  <= '0;
      end else if (w_we_hit) begin
         if (w_is_clb) r_clb_sh <= config_data[CLB_CFG_W-1:0];
         if (w_is_cb0) r_cb0_sh <= config_data[CB_W-1:0];
         if (w_is_cb1) r_cb1_sh <= config_data[CB_W-1:0];
         if (w_is_sb) begin
            for (int b = 0; b < SB_BITS; b++) begin
               if (w_sb_idx == 16'(b / 32)) r_sb_sh[b] <= config_data[b % 32];
            end
         end
      end
   end

   // commit copies the whole shadow bank in one edge so the datapath never sees a mix
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clb_act <= '0;
         r_cb0_act <= '0;
         r_cb1_act <= '0;
         r_sb_act  <= '0;
      end else if (w_we_hit && w_is_commit) begin
         r_clb_act <= r_clb_sh;
         r_cb0_act <= r_cb0_sh;
         r_cb1_act <= r_cb1_sh;
         r_sb_act  <= r_sb_sh;
      end
   end

   // compute block
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_pe_out;

   pe_tile_clb_param #(
      .WIDTH (WIDTH)
   ) u_clb (
      .clk      (clk),
      .reset    (reset),
      .i_cfg    (r_clb_act),
      .i_op_a   (w_op_a),
      .i_op_b   (w_op_b),
      .o_pe_out (w_pe_out)
   );

   // switch box: each output track picks a neighbouring side on the same track or the PE
   always_comb begin
      out_wire = '0;
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < NUM_TRACKS; t++) begin
            case (sb_sel_e'(r_sb_act[2*(s*NUM_TRACKS+t) +: 2]))
               SB_SEL_S1: out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
               SB_SEL_S2: out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
               SB_SEL_S3: out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
               SB_SEL_PE: out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = w_pe_out;
               default:   out_wire[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = '0;
            endcase
         end
      end
   end

   // connect boxes: CB0 taps side 0, CB1 taps side 1; unmatched index yields operand 0
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
         if (r_cb0_act == CB_W'(t))
            w_op_a = in_wire[t*WIDTH +: WIDTH];
         if (r_cb0_act == CB_W'(NUM_TRACKS + t))
            w_op_a = out_wire[t*WIDTH +: WIDTH];
         if (r_cb1_act == CB_W'(t))
            w_op_b = in_wire[(NUM_TRACKS+t)*WIDTH +: WIDTH];
         if (r_cb1_act == CB_W'(NUM_TRACKS + t))
            w_op_b = out_wire[(NUM_TRACKS+t)*WIDTH +: WIDTH];
      end
   end

`ifdef PE_TILE_READBACK_EN
   logic [31:0] r_rdata;
   logic        r_rvalid;
   logic [31:0] w_sb_rd;
   logic [31:0] w_rd_mux;

   // gather the addressed switch-box word, zero-filling bits past the last select
   always_comb begin
      w_sb_rd = '0;
      for (int b = 0; b < SB_BITS; b++) begin
         if (w_sb_idx == 16'(b / 32)) w_sb_rd[b % 32] = r_sb_sh[b];
      end
   end

   // readback source select; COMMIT and unknown targets read as zero
   always_comb begin
      w_rd_mux = '0;
      if (w_is_clb)      w_rd_mux = 32'(r_clb_sh);
      else if (w_is_cb0) w_rd_mux = 32'(r_cb0_sh);
      else if (w_is_cb1) w_rd_mux = 32'(r_cb1_sh);
      else if (w_is_sb)  w_rd_mux = w_sb_rd;
   end

   // read data captured on a hit; valid pulses one cycle, data holds otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else if (config_re && w_hit) begin
         r_rdata  <= w_rd_mux;
         r_rvalid <= 1'b1;
      end else begin
         r_rvalid <= 1'b0;
      end
   end

   assign config_rdata  = r_rdata;
   assign config_rvalid = r_rvalid;
`else
   logic w_unused_re;

   assign w_unused_re   = config_re;
   assign config_rdata  = '0;
   assign config_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
// tb/tb_pe_tile_param.sv - self-checking bench for pe_tile_param (WIDTH=4, NUM_TRACKS=4)
module tb_pe_tile_param;

   localparam logic [15:0] MY_ID    = 16'h0002;
   localparam logic [15:0] OTHER_ID = 16'h0001;
   localparam logic [15:0] T_CLB    = 16'h0004;
   localparam logic [15:0] T_CB1    = 16'h0005;
   localparam logic [15:0] T_CB0    = 16'h0006;
   localparam logic [15:0] T_SB0    = 16'h0007;
   localparam logic [15:0] T_COMMIT = 16'h00FF;

   logic        clk;
   logic        reset;
   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic        config_we;
   logic        config_re;
   logic [15:0] tile_id;
   logic [63:0] in_wire;
   logic [63:0] out_wire;
   logic [31:0] config_rdata;
   logic        config_rvalid;

   pe_tile_param #(
      .WIDTH      (4),
      .NUM_TRACKS (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .config_addr   (config_addr),
      .config_data   (config_data),
      .config_we     (config_we),
      .config_re     (config_re),
      .tile_id       (tile_id),
      .in_wire       (in_wire),
      .out_wire      (out_wire),
      .config_rdata  (config_rdata),
      .config_rvalid (config_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] in;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] exp;
   } sb_item_t;

   int       n_vec  = 0;
   int       n_miss = 0;
   sb_item_t sb_q[$];
   vec_t     vecs[6];

   function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return 4'(a + b);
      endcase
   endfunction

   // reference for a legal (loop-free) combinational configuration
   function automatic logic [63:0] model(input logic [63:0] in, input logic [31:0] sb,
                                         input int cb0, input int cb1, input logic [1:0] op);
      logic [3:0]  pre[16];
      logic [3:0]  a, b, pe;
      logic [63:0] r;
      int          sel;
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < 4; t++) begin
            sel = int'(sb[2*(s*4+t) +: 2]);
            if (sel < 3) pre[s*4+t] = in[(((s+sel+1)%4)*4+t)*4 +: 4];
            else         pre[s*4+t] = 4'h0;
         end
      end
      a  = (cb0 < 4) ? in[cb0*4 +: 4] : pre[cb0-4];
      b  = (cb1 < 4) ? in[(4+cb1)*4 +: 4] : pre[cb1];
      pe = alu(op, a, b);
      for (int i = 0; i < 16; i++) begin
         r[i*4 +: 4] = (sb[2*i +: 2] == 2'd3) ? pe : pre[i];
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out();
      sb_item_t it;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_empty: got nothing expected an entry");
      end else begin
         it = sb_q.pop_front();
         check(it.name, out_wire, it.exp);
      end
   endtask

   // drive operands, queue the expected routing, compare in the same cycle
   task automatic drive_chk(input logic [63:0] in, input logic [63:0] exp, input string nm);
      in_wire = in;
      sb_q.push_back('{nm, exp});
      @(negedge clk);
      check_out();
   endtask

   // queue an expectation for the next cycle with inputs held
   task automatic expect_next(input logic [63:0] exp, input string nm);
      sb_q.push_back('{nm, exp});
      tick();
      @(negedge clk);
      check_out();
   endtask

   task automatic cfg_write(input logic [15:0] tgt, input logic [31:0] d, input logic [15:0] id);
      config_addr = {tgt, id};
      config_data = d;
      config_we   = 1'b1;
      tick();
      config_we   = 1'b0;
   endtask

   // read strobe for one edge, then check data/valid and that valid drops again
   task automatic cfg_read(input logic [15:0] tgt, input logic [15:0] id,
                           input logic [31:0] exp_d, input logic exp_v, input string nm);
      config_addr = {tgt, id};
      config_re   = 1'b1;
      tick();
      config_re   = 1'b0;
      @(negedge clk);
      check({nm, "_rdata"}, 64'(config_rdata), 64'(exp_d));
      check({nm, "_rvalid"}, 64'(config_rvalid), 64'(exp_v));
      tick();
      @(negedge clk);
      check({nm, "_rvalid_drop"}, 64'(config_rvalid), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] v;
      reset = 1'b1; config_addr = '0; config_data = '0; config_we = 1'b0;
      config_re = 1'b0; tile_id = MY_ID; in_wire = '0;

      vecs[0].in = 64'h0000_0000_0A00_0000; vecs[0].exp = 64'h0000_0000_0000_0A00;
      vecs[1].in = 64'h0123_4567_89AB_CDEF; vecs[1].exp = 64'hCDEF_0123_4567_89AB;
      for (int i = 2; i < 6; i++) begin
         vecs[i].in  = {$urandom, $urandom};
         vecs[i].exp = model(vecs[i].in, 32'h0, 0, 0, 2'd0);
      end

      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_rvalid", 64'(config_rvalid), 64'h0);
      check("rst_rdata", 64'(config_rdata), 64'h0);
      for (int i = 0; i < 6; i++) drive_chk(vecs[i].in, vecs[i].exp, $sformatf("rst_default_%0d", i));

      // shadow isolation
      cfg_write(T_SB0, 32'hFFFF_FFFF, MY_ID);
      cfg_write(T_CLB, 32'h0000_0003, MY_ID);
      drive_chk(vecs[1].in, vecs[1].exp, "shadow_isolation");
`ifdef PE_TILE_READBACK_EN
      cfg_read(T_SB0, MY_ID, 32'hFFFF_FFFF, 1'b1, "rb_sb0");
      cfg_read(T_CLB, MY_ID, 32'h3, 1'b1, "rb_clb");
      cfg_read(T_COMMIT, MY_ID, 32'h0, 1'b1, "rb_commit");
`else
      cfg_read(T_SB0, MY_ID, 32'h0, 1'b0, "rb_off");
`endif

      // commit and compute: every track carries 3 + 5
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      drive_chk(64'h0000_0000_0005_0003, {16{4'h8}}, "commit_add");
      v = {$urandom, $urandom};
      v[3:0] = 4'h7; v[19:16] = 4'hB;
      drive_chk(v, {16{4'h2}}, "commit_add_wrap");

      // every opcode, combinational
      for (int op = 0; op < 4; op++) begin
         cfg_write(T_CLB, 32'(op), MY_ID);
         cfg_write(T_COMMIT, 32'h0, MY_ID);
         v = {$urandom, $urandom};
         drive_chk(v, model(v, 32'hFFFF_FFFF, 0, 0, 2'(op)), $sformatf("opcode_%0d", op));
      end

      // connect-box indices into in_wire and out_wire (side 0 routed, not PE)
      cfg_write(T_SB0, 32'hFFFF_FF00, MY_ID);
      cfg_write(T_CB0, 32'h5, MY_ID);
      cfg_write(T_CB1, 32'h3, MY_ID);
      cfg_write(T_CLB, 32'h1, MY_ID);
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      for (int i = 0; i < 2; i++) begin
         v = {$urandom, $urandom};
         drive_chk(v, model(v, 32'hFFFF_FF00, 5, 3, 2'd1), $sformatf("cb_select_%0d", i));
      end

      // pipelined PE: result appears exactly one cycle after the operands
      in_wire = '0;
      cfg_write(T_SB0, 32'hFFFF_FFFF, MY_ID);
      cfg_write(T_CB0, 32'h0, MY_ID);
      cfg_write(T_CB1, 32'h0, MY_ID);
      cfg_write(T_CLB, 32'h7, MY_ID);
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      drive_chk(64'h0000_0000_0002_000F, 64'h0, "pipe_before");
      expect_next({16{4'h1}}, "pipe_after");

      // mismatched tile id leaves the shadow alone
      cfg_write(T_CLB, 32'h0, OTHER_ID);
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      drive_chk(64'h0000_0000_0005_0006, {16{4'h1}}, "mismatch_reg_old");
      expect_next({16{4'hB}}, "mismatch_reg_new");
`ifdef PE_TILE_READBACK_EN
      cfg_read(T_CLB, MY_ID, 32'h7, 1'b1, "rb_mismatch");
      cfg_read(T_CB0, OTHER_ID, 32'h7, 1'b0, "rb_nohit");
      config_addr = {T_CLB, MY_ID};
      config_data = 32'h2;
      config_we = 1'b1;
      config_re = 1'b1;
      tick();
      config_we = 1'b0;
      config_re = 1'b0;
      @(negedge clk);
      check("rb_same_cycle_old", 64'(config_rdata), 64'h7);
      cfg_read(T_CLB, MY_ID, 32'h2, 1'b1, "rb_after_write");
`endif

      // reset between write and commit restores the default routing
      cfg_write(T_SB0, 32'h5555_5555, MY_ID);
      cfg_write(T_CLB, 32'h3, MY_ID);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cfg_write(T_COMMIT, 32'h0, MY_ID);
      for (int i = 0; i < 3; i++) drive_chk(vecs[i].in, vecs[i].exp, $sformatf("reset_mid_%0d", i));
      @(negedge clk);
      check("reset_mid_rvalid", 64'(config_rvalid), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
